edgcol_walker: RTL and testbench

EDGCOL_WALKER -- requirements
Module: edgcol_walker

---
 rtl/edgcol_walker.sv | 121 ++++++++++++
 tb/tb_edgcol_walker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/edgcol_walker.sv
// Walks the straight edge A->B through the occupancy grid in 2^STEP_LOG2 equal segments.
// Optional build macro EDGCOL_EARLY_EXIT_EN ends the walk at the first occupied cell.
module edgcol_walker #(
  parameter int unsigned REG_WIDTH   = 32,
  parameter int unsigned COORD_WIDTH = 8,
  parameter int unsigned STEP_LOG2   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [REG_WIDTH-1:0]   rdData0,
  input  logic [REG_WIDTH-1:0]   rdData1,
  input  logic [REG_WIDTH-1:0]   rdData2,
  input  logic [REG_WIDTH-1:0]   rdData3,
  input  logic [REG_WIDTH-1:0]   rdData4,
  input  logic [REG_WIDTH-1:0]   rdData5,
  output logic                   busy,
  output logic [COORD_WIDTH-1:0] cellX,
  output logic [COORD_WIDTH-1:0] cellY,
  output logic [COORD_WIDTH-1:0] cellZ,
  output logic                   cellValid,
  input  logic                   cellReady,
  input  logic                   occHit,
  output logic                   done,
  output logic                   collision,
  output logic [STEP_LOG2:0]     hitIndex
);

  localparam int unsigned DW = COORD_WIDTH + 1;
  localparam int unsigned AW = COORD_WIDTH + STEP_LOG2 + 1;
  localparam int unsigned IW = STEP_LOG2 + 1;
  localparam logic [IW-1:0] LastIdx = IW'(1) << STEP_LOG2;

  typedef enum logic [1:0] {StIdle, StLoad, StStep, StDone} state_e;

  state_e state_q, state_d;

  logic [COORD_WIDTH-1:0] pt_a [3];
  logic [COORD_WIDTH-1:0] pt_b [3];
  logic signed [AW-1:0]   acc_q [3];
  logic signed [DW-1:0]   dlt_q [3];
  logic [IW-1:0]          idx_q;
  logic                   xfer;
  logic                   early_exit;
  logic                   last_xfer;
  logic                   unused_rd;

  assign pt_a[0] = rdData0[COORD_WIDTH-1:0];
  assign pt_a[1] = rdData1[COORD_WIDTH-1:0];
  assign pt_a[2] = rdData2[COORD_WIDTH-1:0];
  assign pt_b[0] = rdData3[COORD_WIDTH-1:0];
  assign pt_b[1] = rdData4[COORD_WIDTH-1:0];
  assign pt_b[2] = rdData5[COORD_WIDTH-1:0];

  assign unused_rd = ^{rdData0[REG_WIDTH-1:COORD_WIDTH], rdData1[REG_WIDTH-1:COORD_WIDTH],
                       rdData2[REG_WIDTH-1:COORD_WIDTH], rdData3[REG_WIDTH-1:COORD_WIDTH],
                       rdData4[REG_WIDTH-1:COORD_WIDTH], rdData5[REG_WIDTH-1:COORD_WIDTH]};

  assign xfer = (state_q == StStep) && cellReady;

`ifdef EDGCOL_EARLY_EXIT_EN
  assign early_exit = occHit;
`else
  assign early_exit = 1'b0;
`endif

  assign last_xfer = xfer && ((idx_q == LastIdx) || early_exit);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StStep;
      StStep:  if (last_xfer) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      collision <= 1'b0;
      hitIndex  <= '0;
      for (int k = 0; k < 3; k++) begin
        acc_q[k] <= '0;
        dlt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == StLoad) begin
        idx_q     <= '0;
        collision <= 1'b0;
        hitIndex  <= '0;
        for (int k = 0; k < 3; k++) begin
          acc_q[k] <= $signed({1'b0, pt_a[k], {STEP_LOG2{1'b0}}});
          dlt_q[k] <= $signed({1'b0, pt_b[k]}) - $signed({1'b0, pt_a[k]});
        end
      end else if (xfer) begin
        idx_q <= idx_q + IW'(1);
        // Sign-extended delta keeps the accumulator exact; point N lands on B << STEP_LOG2.
        for (int k = 0; k < 3; k++) begin
          acc_q[k] <= acc_q[k] + {{STEP_LOG2{dlt_q[k][DW-1]}}, dlt_q[k]};
        end
        if (occHit && !collision) begin
          collision <= 1'b1;
          hitIndex  <= idx_q;
        end
      end
    end
  end

  assign cellX     = acc_q[0][STEP_LOG2 +: COORD_WIDTH];
  assign cellY     = acc_q[1][STEP_LOG2 +: COORD_WIDTH];
  assign cellZ     = acc_q[2][STEP_LOG2 +: COORD_WIDTH];
  assign busy      = (state_q != StIdle);
  assign cellValid = (state_q == StStep);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_edgcol_walker.sv
// Scoreboard bench for edgcol_walker: expected cells queued per walk, popped on each transfer.
// Honours EDGCOL_EARLY_EXIT_EN the same way the design does.
module tb_edgcol_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] rdData0, rdData1, rdData2, rdData3, rdData4, rdData5;
  logic        busy;
  logic [7:0]  cellX, cellY, cellZ;
  logic        cellValid;
  logic        cellReady;
  logic        occHit;
  logic        done;
  logic        collision;
  logic [4:0]  hitIndex;

  logic        hit_en;
  logic [23:0] hit_cell;
  logic [23:0] exp_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  // Occupancy grid model: one occupied cell.
  assign occHit = hit_en && cellValid && ({cellX, cellY, cellZ} == hit_cell);

  edgcol_walker dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rdData0   (rdData0),
    .rdData1   (rdData1),
    .rdData2   (rdData2),
    .rdData3   (rdData3),
    .rdData4   (rdData4),
    .rdData5   (rdData5),
    .busy      (busy),
    .cellX     (cellX),
    .cellY     (cellY),
    .cellZ     (cellZ),
    .cellValid (cellValid),
    .cellReady (cellReady),
    .occHit    (occHit),
    .done      (done),
    .collision (collision),
    .hitIndex  (hitIndex)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int coord(input int a, input int b, input int i);
    return a + int'($floor(real'((b - a) * i) / 16.0));
  endfunction

  task automatic run_walk(input int ax, input int ay, input int az,
                          input int bx, input int by, input int bz,
                          input logic hit_on, input logic [23:0] tgt,
                          input int stall_pt, input int stall_len, input logic poke_start);
    int   exp_hit, last, xfers, stall_left, exp_lat;
    logic seen;
    logic [23:0] p;
    hit_en   = hit_on;
    hit_cell = tgt;
    exp_q.delete();
    exp_hit  = -1;
    for (int i = 0; i <= 16; i++) begin
      p = {8'(coord(ax, bx, i)), 8'(coord(ay, by, i)), 8'(coord(az, bz, i))};
      exp_q.push_back(p);
      if (hit_on && p == tgt && exp_hit < 0) exp_hit = i;
    end
    last = 16;
`ifdef EDGCOL_EARLY_EXIT_EN
    if (exp_hit >= 0) last = exp_hit;
`endif
    while (exp_q.size() > last + 1) void'(exp_q.pop_back());
    exp_lat = last + 3 + stall_len;
    rdData0 = ax; rdData1 = ay; rdData2 = az;
    rdData3 = bx; rdData4 = by; rdData5 = bz;
    xfers = 0; stall_left = stall_len; seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      start = poke_start && (cyc == 5);
      if (cyc == 2) begin
        rdData0 = $urandom; rdData1 = $urandom; rdData2 = $urandom;
        rdData3 = $urandom; rdData4 = $urandom; rdData5 = $urandom;
      end
      cellReady = 1'b1;
      if (cellValid) begin
        if (xfers == stall_pt && stall_left > 0) begin
          cellReady = 1'b0;
          stall_left--;
        end
        #1;
        if (exp_q.size() == 0) check("extra_cell", 32'(cellValid), 32'd0);
        else if (cellReady) begin
          check("cell", 32'({cellX, cellY, cellZ}), 32'(exp_q.pop_front()));
          xfers++;
        end else check("stall_hold", 32'({cellX, cellY, cellZ}), 32'(exp_q[0]));
      end
      if (done) begin
        seen = 1'b1;
        check("latency", 32'(cyc), 32'(exp_lat));
        check("collision", 32'(collision), 32'(exp_hit >= 0));
        check("hit_index", 32'(hitIndex), (exp_hit >= 0) ? 32'(exp_hit) : 32'd0);
        check("done_no_valid", 32'(cellValid), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        check("left_over", 32'(exp_q.size()), 32'd0);
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    start = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("coll_held", 32'(collision), 32'(exp_hit >= 0));
    @(negedge clk);
    check("still_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_reset();
    hit_en  = 1'b0;
    rdData0 = 0; rdData1 = 0; rdData2 = 0;
    rdData3 = 16; rdData4 = 0; rdData5 = 0;
    cellReady = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      start = (cyc == 5);
    end
    check("rst_pt7", 32'(cellX), 32'd7);
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(cellValid), 32'd0);
    check("rst_cell", 32'({cellX, cellY, cellZ}), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_coll", 32'(collision), 32'd0);
    check("rst_hidx", 32'(hitIndex), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("rst_no_done", 32'(done), 32'd0);
      check("rst_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cellReady = 1'b1; hit_en = 1'b0; hit_cell = '0;
    rdData0 = 0; rdData1 = 0; rdData2 = 0; rdData3 = 0; rdData4 = 0; rdData5 = 0;
    repeat (2) @(negedge clk);
    check("init_busy", 32'(busy), 32'd0);
    check("init_valid", 32'(cellValid), 32'd0);
    check("init_cell", 32'({cellX, cellY, cellZ}), 32'd0);
    check("init_done", 32'(done), 32'd0);
    check("init_coll", 32'(collision), 32'd0);
    check("init_hidx", 32'(hitIndex), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_walk(0, 0, 0, 16, 0, 0, 1'b0, 24'h0, -1, 0, 1'b0);
    run_walk(10, 20, 30, 2, 20, 34, 1'b1, {8'd6, 8'd20, 8'd32}, -1, 0, 1'b0);
    run_walk(3, 100, 200, 40, 90, 180, 1'b0, 24'h0, 4, 3, 1'b0);
    run_walk(5, 5, 5, 5, 5, 5, 1'b1, {8'd5, 8'd5, 8'd5}, -1, 0, 1'b0);
    run_walk(255, 0, 128, 0, 255, 0, 1'b0, 24'h0, -1, 0, 1'b1);
    run_reset();
    run_walk(7, 9, 11, 7, 9, 11, 1'b0, 24'h0, 16, 2, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
